// File: rtl/mem_reduce_unit.sv
// -----------------------------------------------------------------------------
// mem_reduce_unit
// DEPTH x DATA_W register file with a host write/read port and a start-triggered
// sequential reducer. The reducer scans mem[lo_addr..hi_addr] (wrapping through
// DEPTH-1 to 0) and returns the sum, unsigned max, unsigned min or the count of
// nonzero words.
//
// Optional feature macro: MEM_REDUCE_SAT_EN
//   defined   : sum/count saturate at 2**ACC_W-1, o_ovf is a sticky clip flag
//   undefined : sum/count wrap modulo 2**ACC_W, o_ovf tied low
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      asynchronous active-high reset (clears memory too)
//   i_addr     host read/write address
//   i_we       write enable (ignored while busy)
//   i_din      write data
//   i_re       read enable; o_dout is registered, 1-cycle latency
//   o_dout     read data, held when i_re is low
//   i_start    begin a reduction (sampled only in idle)
//   i_mode     00 sum, 01 max, 10 min, 11 nonzero count
//   i_lo_addr  first address of the range
//   i_hi_addr  last address of the range
//   o_busy     high from the start edge until the return to idle
//   o_done     one-cycle result-valid pulse
//   o_ans      result, held until the next done
//   o_ovf      sticky saturation flag
// -----------------------------------------------------------------------------
module mem_reduce_unit #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int ACC_W  = DATA_W + ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_we,
   input  logic [DATA_W-1:0] i_din,
   input  logic              i_re,
   output logic [DATA_W-1:0] o_dout,
   input  logic              i_start,
   input  logic [1:0]        i_mode,
   input  logic [ADDR_W-1:0] i_lo_addr,
   input  logic [ADDR_W-1:0] i_hi_addr,
   output logic              o_busy,
   output logic              o_done,
   output logic [ACC_W-1:0]  o_ans,
   output logic              o_ovf
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2; // last fold settled, result latched on exit
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [1:0] MODE_SUM = 2'b00;
   localparam logic [1:0] MODE_MAX = 2'b01;
   localparam logic [1:0] MODE_MIN = 2'b10;
   localparam logic [1:0] MODE_CNT = 2'b11;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_dout;
   logic [1:0]        r_state;
   logic [1:0]        r_mode;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_cnt;
   logic [ACC_W-1:0]  r_acc;
   logic [ACC_W-1:0]  r_ans;

   logic              w_busy;
   logic              w_start_ok;
   logic [DATA_W-1:0] w_word;
   logic [ACC_W-1:0]  w_word_ext;
   logic [ACC_W-1:0]  w_addend;
   logic [ACC_W-1:0]  w_sum;
   logic [ACC_W-1:0]  w_acc_next;
   logic [ACC_W-1:0]  w_acc_init;

   assign w_busy     = (r_state != S_IDLE);
   assign w_start_ok = (r_state == S_IDLE) && i_start;
   assign w_word     = r_mem[r_ptr];
   assign w_word_ext = ACC_W'(w_word);
   assign w_addend   = (r_mode == MODE_CNT) ? ACC_W'(w_word != '0) : w_word_ext;

`ifdef MEM_REDUCE_SAT_EN
   logic [ACC_W:0] w_sum_full;
   logic           w_clip;
   logic           r_ovf;

   assign w_sum_full = {1'b0, r_acc} + {1'b0, w_addend};
   assign w_clip     = w_sum_full[ACC_W] && ((r_mode == MODE_SUM) || (r_mode == MODE_CNT));
   assign w_sum      = w_sum_full[ACC_W] ? '1 : w_sum_full[ACC_W-1:0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ovf <= 1'b0;
      end else if (w_start_ok) begin
         r_ovf <= 1'b0;
      end else if ((r_state == S_RUN) && w_clip) begin
         r_ovf <= 1'b1;
      end
   end

   assign o_ovf = r_ovf;
`else
   assign w_sum = r_acc + w_addend;
   assign o_ovf = 1'b0;
`endif

   always_comb begin
      w_acc_next = w_sum;
      unique case (r_mode)
         MODE_MAX: w_acc_next = (w_word_ext > r_acc) ? w_word_ext : r_acc;
         MODE_MIN: w_acc_next = (w_word_ext < r_acc) ? w_word_ext : r_acc;
         default:  w_acc_next = w_sum;
      endcase
   end

   // Min starts from the largest possible word so the first element always wins.
   assign w_acc_init = (i_mode == MODE_MIN) ? ACC_W'({DATA_W{1'b1}}) : '0;

   // Memory and read port
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_dout <= '0;
      end else begin
         if (i_we && !w_busy) begin
            r_mem[i_addr] <= i_din;
         end
         // Non-blocking read returns pre-write data on a same-address collision.
         if (i_re) begin
            r_dout <= r_mem[i_addr];
         end
      end
   end

   // Reducer control and datapath
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_mode  <= MODE_SUM;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_ans   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_mode  <= i_mode;
                  r_ptr   <= i_lo_addr;
                  // Modular difference gives N-1 directly, including wrapped ranges.
                  r_cnt   <= i_hi_addr - i_lo_addr;
                  r_acc   <= w_acc_init;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc <= w_acc_next;
               r_ptr <= r_ptr + 1'b1;
               if (r_cnt == '0) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DRAIN: begin
               r_ans   <= r_acc;
               r_state <= S_DONE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_dout = r_dout;
   assign o_busy = w_busy;
   assign o_done = (r_state == S_DONE);
   assign o_ans  = r_ans;

endmodule

// File: tb/tb_mem_reduce_unit.sv
module tb_mem_reduce_unit;

   logic        clk;
   logic        rst;

   // Default-parameter DUT (ACC_W = 11)
   logic [2:0]  addr;
   logic        we;
   logic [7:0]  din;
   logic        re;
   logic [7:0]  dout;
   logic        start;
   logic [1:0]  mode;
   logic [2:0]  lo_addr;
   logic [2:0]  hi_addr;
   logic        busy;
   logic        done;
   logic [10:0] ans;
   logic        ovf;

   // Narrow-accumulator DUT (ACC_W = 8)
   logic [2:0]  b_addr;
   logic        b_we;
   logic [7:0]  b_din;
   logic        b_re;
   logic [7:0]  b_dout;
   logic        b_start;
   logic [1:0]  b_mode;
   logic [2:0]  b_lo_addr;
   logic [2:0]  b_hi_addr;
   logic        b_busy;
   logic        b_done;
   logic [7:0]  b_ans;
   logic        b_ovf;

   int n_checks = 0;
   int n_errors = 0;

   mem_reduce_unit dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_addr    (addr),
      .i_we      (we),
      .i_din     (din),
      .i_re      (re),
      .o_dout    (dout),
      .i_start   (start),
      .i_mode    (mode),
      .i_lo_addr (lo_addr),
      .i_hi_addr (hi_addr),
      .o_busy    (busy),
      .o_done    (done),
      .o_ans     (ans),
      .o_ovf     (ovf)
   );

   mem_reduce_unit #(
      .DATA_W (8),
      .ADDR_W (3),
      .ACC_W  (8)
   ) dut_narrow (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_addr    (b_addr),
      .i_we      (b_we),
      .i_din     (b_din),
      .i_re      (b_re),
      .o_dout    (b_dout),
      .i_start   (b_start),
      .i_mode    (b_mode),
      .i_lo_addr (b_lo_addr),
      .i_hi_addr (b_hi_addr),
      .o_busy    (b_busy),
      .o_done    (b_done),
      .o_ans     (b_ans),
      .o_ovf     (b_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      addr = a;
      din  = d;
      we   = 1'b1;
      tick();
      we   = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if (dout !== 8'd0) begin
         n_errors++;
         $display("FAIL reset_dout: got %0d expected 0", dout);
      end
      n_checks++;
      if (ans !== 11'd0) begin
         n_errors++;
         $display("FAIL reset_ans: got %0d expected 0", ans);
      end
      n_checks++;
      if (done !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_done: got %b expected 0", done);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      n_checks++;
      if (ovf !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_ovf: got %b expected 0", ovf);
      end
      rst = 1'b0;
      tick();
      addr = 3'd3;
      re   = 1'b1;
      tick();
      re   = 1'b0;
      n_checks++;
      if (dout !== 8'd0) begin
         n_errors++;
         $display("FAIL reset_mem_read: got %0d expected 0", dout);
      end
   endtask

   task automatic test_write_read;
      logic [7:0] exp_d;
      for (int i = 0; i < 6; i++) begin
         wr(3'(i), 8'((i + 1) * 10));
      end
      for (int i = 0; i < 6; i++) begin
         exp_d = 8'((i + 1) * 10);
         addr  = 3'(i);
         re    = 1'b1;
         tick();
         re    = 1'b0;
         n_checks++;
         if (dout !== exp_d) begin
            n_errors++;
            $display("FAIL read_addr%0d: got %0d expected %0d", i, dout, exp_d);
         end
      end
   endtask

   // Pulses start and watches done/busy; latency counted in edges after the start edge.
   task automatic run_reduce(input logic [1:0] m, input logic [2:0] lo, input logic [2:0] hi,
                             input logic [10:0] exp_ans, input int exp_lat, input string name);
      int          lat;
      int          done_cnt;
      int          busy_cnt;
      logic [10:0] got;
      mode    = m;
      lo_addr = lo;
      hi_addr = hi;
      start   = 1'b1;
      tick();
      start    = 1'b0;
      lat      = -1;
      done_cnt = 0;
      busy_cnt = busy ? 1 : 0;
      got      = '0;
      for (int j = 1; j <= 30; j++) begin
         tick();
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (lat < 0) lat = j;
            got = ans;
         end
         if (!busy) break;
      end
      n_checks++;
      if (lat != exp_lat) begin
         n_errors++;
         $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
      end
      n_checks++;
      if (got !== exp_ans) begin
         n_errors++;
         $display("FAIL %s_ans: got %0d expected %0d", name, got, exp_ans);
      end
      n_checks++;
      if (done_cnt != 1) begin
         n_errors++;
         $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt);
      end
      n_checks++;
      if (busy_cnt != exp_lat + 1) begin
         n_errors++;
         $display("FAIL %s_busy_cycles: got %0d expected %0d", name, busy_cnt, exp_lat + 1);
      end
      n_checks++;
      if (ans !== exp_ans) begin
         n_errors++;
         $display("FAIL %s_ans_held: got %0d expected %0d", name, ans, exp_ans);
      end
   endtask

   task automatic test_modes;
      run_reduce(2'b00, 3'd0, 3'd7, 11'd210, 9, "sum_full");
      n_checks++;
      if (ovf !== 1'b0) begin
         n_errors++;
         $display("FAIL sum_full_ovf: got %b expected 0", ovf);
      end
      run_reduce(2'b01, 3'd1, 3'd4, 11'd50, 5, "max_1_4");
      run_reduce(2'b10, 3'd1, 3'd4, 11'd20, 5, "min_1_4");
      run_reduce(2'b11, 3'd0, 3'd7, 11'd6, 9, "count_full");
   endtask

   task automatic test_ignore_during_run;
      int done_cnt;
      mode    = 2'b00;
      lo_addr = 3'd0;
      hi_addr = 3'd7;
      start   = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      // Disturb the run: write, new start and changed mode/range.
      addr    = 3'd0;
      din     = 8'd99;
      we      = 1'b1;
      start   = 1'b1;
      mode    = 2'b10;
      lo_addr = 3'd2;
      hi_addr = 3'd3;
      tick();
      we       = 1'b0;
      start    = 1'b0;
      done_cnt = done ? 1 : 0;
      for (int j = 0; j < 30; j++) begin
         tick();
         if (done) done_cnt++;
         if (!busy) break;
      end
      n_checks++;
      if (ans !== 11'd210) begin
         n_errors++;
         $display("FAIL ignore_ans: got %0d expected 210", ans);
      end
      n_checks++;
      if (done_cnt != 1) begin
         n_errors++;
         $display("FAIL ignore_done_count: got %0d expected 1", done_cnt);
      end
      tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++;
         $display("FAIL ignore_no_restart: busy %b expected 0", busy);
      end
      addr = 3'd0;
      re   = 1'b1;
      tick();
      re   = 1'b0;
      n_checks++;
      if (dout !== 8'd10) begin
         n_errors++;
         $display("FAIL ignore_mem0: got %0d expected 10", dout);
      end
   endtask

   task automatic test_wrap;
      wr(3'd6, 8'd5);
      wr(3'd7, 8'd7);
      run_reduce(2'b00, 3'd6, 3'd1, 11'd42, 5, "wrap_sum");
   endtask

   task automatic test_reset_mid_run;
      int done_seen;
      addr    = 3'd1;
      re      = 1'b1;
      mode    = 2'b00;
      lo_addr = 3'd0;
      hi_addr = 3'd7;
      start   = 1'b1;
      tick();
      re    = 1'b0;
      start = 1'b0;
      tick();
      tick();
      n_checks++;
      if (busy !== 1'b1 || dout !== 8'd20) begin
         n_errors++;
         $display("FAIL pre_reset_state: busy %b dout %0d expected busy 1 dout 20", busy, dout);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || ans !== 11'd0 || dout !== 8'd0) begin
         n_errors++;
         $display("FAIL mid_run_reset: busy %b done %b ans %0d dout %0d expected all 0",
                  busy, done, ans, dout);
      end
      tick();
      rst       = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         addr = 3'(i);
         re   = 1'b1;
         tick();
         re   = 1'b0;
         if (done) done_seen++;
         n_checks++;
         if (dout !== 8'd0) begin
            n_errors++;
            $display("FAIL post_reset_read%0d: got %0d expected 0", i, dout);
         end
      end
      n_checks++;
      if (done_seen != 0) begin
         n_errors++;
         $display("FAIL post_reset_done: got %0d pulses expected 0", done_seen);
      end
      n_checks++;
      if (ans !== 11'd0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL post_reset_idle: ans %0d busy %b expected 0 0", ans, busy);
      end
   endtask

   task automatic test_saturation;
      logic [7:0] exp_ans;
      logic       exp_ovf;
      int         seen;
`ifdef MEM_REDUCE_SAT_EN
      exp_ans = 8'd255;
      exp_ovf = 1'b1;
`else
      exp_ans = 8'd248;
      exp_ovf = 1'b0;
`endif
      for (int i = 0; i < 8; i++) begin
         b_addr = 3'(i);
         b_din  = 8'd255;
         b_we   = 1'b1;
         tick();
      end
      b_we      = 1'b0;
      b_mode    = 2'b00;
      b_lo_addr = 3'd0;
      b_hi_addr = 3'd7;
      b_start   = 1'b1;
      tick();
      b_start = 1'b0;
      seen    = 0;
      for (int j = 0; j < 30; j++) begin
         tick();
         if (b_done) begin
            seen = 1;
            break;
         end
      end
      n_checks++;
      if (seen == 0) begin
         n_errors++;
         $display("FAIL narrow_done_timeout: no done within 30 cycles");
      end
      n_checks++;
      if (b_ans !== exp_ans) begin
         n_errors++;
         $display("FAIL narrow_sum_ans: got %0d expected %0d", b_ans, exp_ans);
      end
      n_checks++;
      if (b_ovf !== exp_ovf) begin
         n_errors++;
         $display("FAIL narrow_sum_ovf: got %b expected %b", b_ovf, exp_ovf);
      end
   endtask

   initial begin
      rst       = 1'b1;
      addr      = '0;
      we        = 1'b0;
      din       = '0;
      re        = 1'b0;
      start     = 1'b0;
      mode      = '0;
      lo_addr   = '0;
      hi_addr   = '0;
      b_addr    = '0;
      b_we      = 1'b0;
      b_din     = '0;
      b_re      = 1'b0;
      b_start   = 1'b0;
      b_mode    = '0;
      b_lo_addr = '0;
      b_hi_addr = '0;

      test_reset();
      test_write_read();
      test_modes();
      test_ignore_during_run();
      test_wrap();
      test_saturation();
      test_reset_mid_run();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_reduce_unit.md
# mem_reduce_unit

Parametrised register-file reduction engine: a DEPTH×DATA_W memory with a host write/read port and a start-triggered sequential reducer that scans a programmable address range and returns sum, max, min or nonzero-count. It generalises the fixed 8×8 sum-only lab block with configurable width, depth and result width, selectable reduction mode, wrap-around ranges, a busy flag and optional saturation. It sits between the host stimulus/control logic and the result display path.

## Interface
- DATA_W, 8, memory word width
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W
- ACC_W, DATA_W+ADDR_W, accumulator/result width (≥ DATA_W)

- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- addr  in  ADDR_W  host read/write address
- we  in  1  write enable
- din  in  DATA_W  write data
- re  in  1  read enable
- dout  out  DATA_W  registered read data
- start  in  1  begin reduction (sampled in IDLE only)
- mode  in  2  00 sum, 01 max, 10 min, 11 count of nonzero words
- lo_addr  in  ADDR_W  first address of range
- hi_addr  in  ADDR_W  last address of range
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle result-valid pulse
- ans  out  ACC_W  result, held until next done
- ovf  out  1  sticky sum/count saturation flag

## Operation
- Reset: all memory words 0, dout 0, ans 0, done 0, busy 0, ovf 0, state IDLE.
- Write: we=1 at edge writes din to mem[addr]; ignored while busy.
- Read: re=1 at edge loads dout <= mem[addr]; dout holds otherwise; reads allowed while busy. we and re same edge, same address: dout gets old data.
- States: IDLE -> RUN on start; RUN -> DONE after N elements; DONE -> IDLE unconditionally.
- On start edge: latch mode, ptr <= lo_addr, cnt <= N-1, clear ovf, init acc (sum/count 0, max 0, min zero-extended all-ones DATA_W).
- N = ((hi_addr - lo_addr) mod DEPTH) + 1; lo > hi wraps through DEPTH-1 to 0; lo == hi gives N=1; full range is lo = hi+1 mod DEPTH.
- RUN: each cycle folds mem[ptr] into acc, ptr increments modulo DEPTH.
- Max/min compare unsigned; result zero-extended to ACC_W.
- Sum/count overflow: see Configuration.
- start while busy ignored; mode/lo/hi changes during RUN ignored.

## Timing
- Read latency 1 cycle.
- Start sampled at edge k: RUN for edges k+1..k+N; at edge k+N+1 ans <= final acc, done=1 for exactly that cycle, busy remains 1; edge k+N+2 back to IDLE, busy 0.
- Earliest next start accepted at edge k+N+2 (start high in the IDLE cycle after done).
- rst asserted any time (incl. mid-RUN) clears immediately; no done pulse; memory cleared.

## Configuration
- MEM_REDUCE_SAT_EN defined: sum and count saturate at 2**ACC_W-1; ovf set on any clipped add, held until next start or rst.
- Undefined: sum/count wrap modulo 2**ACC_W; ovf tied 0.

## Test plan
- Defaults, write 10,20,30,40,50,60 to addr 0..5, read back -> dout equals each value one cycle after re; mode 00, lo 0, hi 7, start -> done pulse exactly 9 cycles after start edge, ans 210, busy 1 for 10 cycles.
- Same data, mode 01 lo 1 hi 4 -> ans 50; mode 10 lo 1 hi 4 -> ans 20; mode 11 lo 0 hi 7 -> ans 6.
- Wrap: mem[6]=5, mem[7]=7, lo 6, hi 1 (N=4) mode 00 -> ans 5+7+10+20=42, done 5 cycles after start.
- Write addr 0 din 99 and start pulses during RUN -> ignored: mem[0] still 10, ans unchanged, single done.
- ACC_W=8, all words 255, sum full range: with MEM_REDUCE_SAT_EN ans 255, ovf 1; without ans 248 (2040 mod 256), ovf 0.
- rst asserted mid-RUN -> busy/done/ans/dout 0 same cycle, subsequent read of any address returns 0, no done pulse.
